// File: rtl/avia_req_tx.sv
// avia_req_tx -- serial request transmitter with acknowledge and retry.
//
// Sends a 3-byte frame (0xA5 sync, {seat,flight} payload, sync^payload
// checksum) as UART-style characters: start 0, 8 data bits LSB first,
// even parity, stop 1, each bit held BIT_DIV cycles, bytes back-to-back.
// After the last stop bit it waits up to ACK_TIMEOUT cycles for ack_in.
// On timeout it resends the same frame up to RETRIES times, then gives up.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   request strobe, only looked at while idle
//   flight  4-bit flight code, captured on start acceptance
//   seat    4-bit seat code, captured on start acceptance
//   ack_in  acknowledge level, synchronous to clk, only looked at in WAIT_ACK
//   tx      registered serial output, idle high
//   busy    high from start acceptance until back in IDLE
//   done    one-cycle pulse on acknowledge
//   error   one-cycle pulse when every attempt has timed out
module avia_req_tx #(
  parameter int BIT_DIV     = 434,
  parameter int ACK_TIMEOUT = 50000,
  parameter int RETRIES     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] flight,
  input  logic [3:0] seat,
  input  logic       ack_in,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_ACK
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  // Counters are sized for the largest legal parameters so a single
  // period can never wrap.
  localparam logic [15:0] BIT_LAST  = 16'(BIT_DIV - 1);
  localparam logic [19:0] WAIT_LAST = 20'(ACK_TIMEOUT - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(RETRIES);

  state_t      state_reg, state_next;
  logic [15:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [2:0]  retry_reg, retry_next;
  logic [19:0] wait_cnt_reg, wait_cnt_next;
  logic [7:0]  payload_reg, payload_next;
  logic        tx_reg, tx_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        error_reg, error_next;

  logic [7:0] frame_byte [3];
  logic [2:0] frame_par;
  logic [7:0] cur_byte;
  logic       cur_par;
  logic       bit_end;

  assign frame_byte[0] = SYNC_BYTE;
  assign frame_byte[1] = payload_reg;
  assign frame_byte[2] = SYNC_BYTE ^ payload_reg;

  // Even parity: the parity bit makes the total count of ones even.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_par
      assign frame_par[gi] = ^frame_byte[gi];
    end
  endgenerate

  always_comb begin
    cur_byte = frame_byte[2];
    cur_par  = frame_par[2];
    case (byte_idx_reg)
      2'd0: begin
        cur_byte = frame_byte[0];
        cur_par  = frame_par[0];
      end
      2'd1: begin
        cur_byte = frame_byte[1];
        cur_par  = frame_par[1];
      end
      default: begin
        cur_byte = frame_byte[2];
        cur_par  = frame_par[2];
      end
    endcase
  end

  assign bit_end = (bit_cnt_reg == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      retry_reg    <= '0;
      wait_cnt_reg <= '0;
      payload_reg  <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
      retry_reg    <= retry_next;
      wait_cnt_reg <= wait_cnt_next;
      payload_reg  <= payload_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  // tx_next is derived from the current state, so the line lags the state
  // register by one cycle: the start bit appears on the edge after the one
  // that accepts the request, and each bit still lasts BIT_DIV cycles.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    retry_next    = retry_reg;
    wait_cnt_next = wait_cnt_reg;
    payload_next  = payload_reg;
    tx_next       = 1'b1;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    error_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          payload_next  = {seat, flight};
          busy_next     = 1'b1;
          retry_next    = '0;
          bit_cnt_next  = '0;
          bit_idx_next  = '0;
          byte_idx_next = '0;
          state_next    = START;
        end
      end

      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          bit_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end

      DATA: begin
        tx_next = cur_byte[bit_idx_reg];
        if (bit_end) begin
          bit_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            bit_idx_next = '0;
            state_next   = PARITY;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end

      PARITY: begin
        tx_next = cur_par;
        if (bit_end) begin
          bit_cnt_next = '0;
          state_next   = STOP;
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          bit_cnt_next = '0;
          if (byte_idx_reg == 2'd2) begin
            byte_idx_next = '0;
            wait_cnt_next = '0;
            state_next    = WAIT_ACK;
          end else begin
            byte_idx_next = byte_idx_reg + 2'd1;
            state_next    = START;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end

      WAIT_ACK: begin
        tx_next = 1'b1;
        // Acknowledge is tested first so it wins over a coincident timeout.
        if (ack_in) begin
          done_next     = 1'b1;
          busy_next     = 1'b0;
          wait_cnt_next = '0;
          state_next    = IDLE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          wait_cnt_next = '0;
          if (retry_reg < RETRY_MAX) begin
            retry_next    = retry_reg + 3'd1;
            bit_cnt_next  = '0;
            bit_idx_next  = '0;
            byte_idx_next = '0;
            state_next    = START;
          end else begin
            error_next = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 20'd1;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign tx    = tx_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign error = error_reg;

endmodule

// File: tb/tb_avia_req_tx.sv
// Testbench for avia_req_tx with BIT_DIV=4, ACK_TIMEOUT=20, RETRIES=1.
// The expected line is built bit by bit from the frame definition and
// compared against tx every cycle; handshake outputs are predicted from
// the acknowledge schedule chosen for each attempt.
module tb_avia_req_tx;

  localparam int BIT_DIV     = 4;
  localparam int ACK_TIMEOUT = 20;
  localparam int RETRIES     = 1;
  localparam int FRAME_BITS  = 33;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] flight = 4'd0;
  logic [3:0] seat = 4'd0;
  logic       ack_in = 1'b0;
  logic       tx;
  logic       busy;
  logic       done;
  logic       error;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  avia_req_tx #(
    .BIT_DIV    (BIT_DIV),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .RETRIES    (RETRIES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .flight(flight),
    .seat  (seat),
    .ack_in(ack_in),
    .tx    (tx),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame bytes: sync, payload, checksum.
  function automatic logic [7:0] frame_byte(input int i, input logic [7:0] payload);
    if (i == 0) return 8'hA5;
    if (i == 1) return payload;
    return 8'hA5 ^ payload;
  endfunction

  // Bit n (0..32) of the serial frame as seen on the line.
  function automatic logic frame_bit(input logic [7:0] payload, input int n);
    logic [7:0] b;
    int pos;
    b   = frame_byte(n / 11, payload);
    pos = n % 11;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9) return (($countones(b) % 2) == 1);
    return 1'b1;
  endfunction

  // Present a request; it is taken on the next rising edge.
  task automatic accept(input logic [3:0] f, input logic [3:0] s);
    flight = f;
    seat   = s;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_tx_still_idle", tx, 1);
    check("accept_no_pulse", {done, error}, 0);
  endtask

  // One full request. ack0/ack1 give the WAIT_ACK cycle (0..19) in which
  // ack_in is raised on the first/second attempt; other values mean none.
  // noisy: toggle start/flight/seat/ack_in randomly while the frame goes out.
  task automatic run_request(input logic [3:0] f, input logic [3:0] s,
                             input int ack0, input int ack1,
                             input bit chain, input bit noisy);
    logic [7:0] payload;
    int ack_w;
    bit finished;
    payload  = {s, f};
    finished = 1'b0;
    accept(f, s);
    for (int a = 0; a <= RETRIES && !finished; a++) begin
      for (int k = 0; k < FRAME_BITS * BIT_DIV; k++) begin
        if (noisy) begin
          ack_in = 1'($urandom_range(0, 1));
          if (k >= 11 * BIT_DIV && k < 22 * BIT_DIV) begin
            start  = 1'b1;
            flight = 4'd9;
            seat   = 4'($urandom);
          end else begin
            start  = 1'($urandom_range(0, 1));
            flight = 4'($urandom);
            seat   = 4'($urandom);
          end
        end
        @(negedge clk);
        check("frame_tx", tx, frame_bit(payload, k / BIT_DIV));
        check("frame_busy", busy, 1);
        check("frame_no_pulse", {done, error}, 0);
      end
      start  = 1'b0;
      ack_in = 1'b0;
      ack_w  = (a == 0) ? ack0 : ack1;
      for (int w = 0; w < ACK_TIMEOUT && !finished; w++) begin
        ack_in = (w == ack_w);
        @(negedge clk);
        ack_in = 1'b0;
        if (w == ack_w) begin
          check("ack_done", done, 1);
          check("ack_no_error", error, 0);
          check("ack_busy_low", busy, 0);
          finished = 1'b1;
        end else if (w == ACK_TIMEOUT - 1) begin
          if (a == RETRIES) begin
            check("timeout_error", error, 1);
            check("timeout_no_done", done, 0);
            check("timeout_busy_low", busy, 0);
            finished = 1'b1;
          end else begin
            check("retry_no_pulse", {done, error}, 0);
            check("retry_busy", busy, 1);
            check("retry_tx_idle", tx, 1);
          end
        end else begin
          check("wait_tx_idle", tx, 1);
          check("wait_busy", busy, 1);
          check("wait_no_pulse", {done, error}, 0);
        end
      end
    end
    if (!chain) begin
      @(negedge clk);
      check("pulse_one_cycle", {done, error}, 0);
      for (int i = 0; i < 2 * ACK_TIMEOUT; i++) begin
        @(negedge clk);
        check("after_tx_quiet", tx, 1);
        check("after_busy_low", busy, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rf, rs;
    int a0, a1;
    bit ch;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_pulses", {done, error}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
    end

    // Basic frame 0xA5 0x73 0xD6, ack five cycles into WAIT_ACK
    run_request(4'd3, 4'd7, 5, -1, 1'b0, 1'b0);
    // No ack at all: frame, retry frame, error
    run_request(4'd3, 4'd7, -1, -1, 1'b0, 1'b0);
    // Start/flight changes during the frame are ignored
    run_request(4'd3, 4'd7, 2, -1, 1'b0, 1'b1);
    // Ack on the timeout cycle of the first and of the second attempt
    run_request(4'd5, 4'd10, ACK_TIMEOUT - 1, -1, 1'b0, 1'b0);
    run_request(4'd12, 4'd1, -1, ACK_TIMEOUT - 1, 1'b0, 1'b0);
    // Ack in the very first WAIT_ACK cycle, start held into the next request
    run_request(4'd0, 4'd0, 0, -1, 1'b1, 1'b0);
    run_request(4'd15, 4'd15, 7, -1, 1'b0, 1'b0);

    // Randomized requests
    for (int n = 0; n < 8; n++) begin
      rf = 4'($urandom);
      rs = 4'($urandom);
      a0 = int'($urandom_range(0, 26));
      a1 = int'($urandom_range(0, 26));
      ch = 1'($urandom_range(0, 1));
      run_request(rf, rs, a0, a1, ch, 1'b1);
    end
    repeat (3) @(negedge clk);

    // Reset mid-frame: line returns high immediately, no clock edge needed
    accept(4'd3, 4'd7);
    repeat (45) @(negedge clk);
    check("midframe_tx_low", tx, 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_busy", busy, 0);
    check("async_reset_pulses", {done, error}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("post_reset_tx", tx, 1);
      check("post_reset_busy", busy, 0);
    end

    // Block works normally after the abort
    run_request(4'd6, 4'd2, 10, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/avia_req_tx.md
AVIA_REQ_TX -- requirements
Module: avia_req_tx

Interface
REQ-001 Parameter BIT_DIV, default 434, meaning clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter ACK_TIMEOUT, default 50000, meaning cycles to wait for ack after the last stop bit; legal range 1..2^20-1.
REQ-003 Parameter RETRIES, default 3, meaning retransmissions allowed after the first attempt; legal range 0..7.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request strobe; sampled only in IDLE.
REQ-007 flight  input  4  flight code; captured when start is accepted.
REQ-008 seat  input  4  seat code; captured when start is accepted.
REQ-009 ack_in  input  1  acknowledge level from the receiving board; already synchronous to clk.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy  output  1  high from start acceptance until return to IDLE.
REQ-012 done  output  1  one-cycle pulse when the request is acknowledged.
REQ-013 error  output  1  one-cycle pulse when all retries time out.

Function
REQ-014 Frame SHALL be 3 bytes in order: 0xA5 sync, payload {seat,flight}, checksum = sync XOR payload.
REQ-015 Each byte SHALL be sent as start bit 0, 8 data bits LSB first, even parity bit, stop bit 1: 11 bits, each held exactly BIT_DIV cycles.
REQ-016 Bytes SHALL be sent back-to-back with no idle gap; whole frame = 33*BIT_DIV cycles.
REQ-017 States: IDLE, START, DATA, PARITY, STOP, WAIT_ACK; tx is a registered output.
REQ-018 IDLE: start=1 at a rising edge captures flight/seat, sets busy, clears the retry counter, enters START; tx goes low on the following edge.
REQ-019 START -> DATA -> PARITY -> STOP, each transition after its BIT_DIV-cycle period (DATA after 8 periods); STOP of bytes 0/1 -> START of next byte; STOP of byte 2 -> WAIT_ACK.
REQ-020 WAIT_ACK: tx=1; ack_in=1 in any cycle -> done pulse, busy low, IDLE on the same edge.
REQ-021 WAIT_ACK: ACK_TIMEOUT cycles without ack_in -> if retry count < RETRIES, increment it and resend the full frame from START with the same captured data; otherwise pulse error and go to IDLE.
REQ-022 ack_in outside WAIT_ACK SHALL be ignored.
REQ-023 start while busy SHALL be ignored, with no queuing; flight/seat changes while busy SHALL NOT alter the frame.
REQ-024 ack_in and the timeout expiring in the same cycle: ack wins; done pulses and error does not.
REQ-025 done and error SHALL never be high together and never pulse while busy is low before the pulse cycle.
REQ-026 Bit-period and timeout counters SHALL be sized for the parameter maxima with no wrap inside one period.
REQ-027 start held high across the return to IDLE SHALL begin a new request on the first IDLE cycle.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, tx=1, busy=0, done=0, error=0, all counters and captured data 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame at once with no further bits; after release the block waits in IDLE for a new start.
REQ-030 First start accepted SHALL be the first rising edge with rst_n high and start high.

Verification (BIT_DIV=4, ACK_TIMEOUT=20, RETRIES=1)
REQ-031 Reset check: rst_n=0 mid-frame -> tx=1 and busy=0 without waiting for a clock edge; no tx toggling after release until start.
REQ-032 Basic frame: flight=3, seat=7, start pulse -> tx bytes 0xA5 (parity 0), 0x73 (parity 1), 0xD6 (parity 1), each bit 4 cycles, 132 cycles total.
REQ-033 Ack: ack_in=1 pulsed 5 cycles into WAIT_ACK -> done for 1 cycle, busy falls that cycle, error stays 0.
REQ-034 Retry/error: ack_in held 0 -> frame, 20 idle cycles, identical second frame, 20 cycles, error pulse, busy=0, no third frame.
REQ-035 Busy guard: start plus flight=9 during byte 1 -> ignored; payload stays 0x73.
REQ-036 Tie: ack_in=1 exactly on the timeout cycle -> done=1, error=0, no retransmission.
